// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the product-stream accumulator.
// The optional MULT_ACC_SATURATE_EN macro is consumed by acc_sat_adder.
package mult_acc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ACC_W_DEF  = 48;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/acc_sat_adder.sv
// Accumulator adder: ACC_W+1 bit sum of the running total and a zero-extended product.
// With MULT_ACC_SATURATE_EN defined, a carry out clamps the result to all-ones; otherwise it wraps.
module acc_sat_adder
    import mult_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] add_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - DATA_W){1'b0}}, add_i};
    assign carry_o  = full_sum[ACC_W];

`ifdef MULT_ACC_SATURATE_EN
    // Once clamped, further non-negative addends keep carrying, so the clamp holds for the run.
    assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Sums runs of LEN unsigned products and presents each total on a valid/ready port.
// Overflow handling (wrap or clamp) is selected by MULT_ACC_SATURATE_EN inside acc_sat_adder.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [DATA_W-1:0] prod_data,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [ACC_W-1:0]  sum_data,
    output logic              sum_ovf,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CNT_W-1:0]  len_q,   len_d;
    logic              ovf_q,   ovf_d;

    logic              beat;
    logic              start_run;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  len_eff;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;

    assign sum_valid  = (state_q == HOLD);
    assign prod_ready = (state_q == HOLD) ? sum_ready : 1'b1;
    assign beat       = prod_valid & prod_ready;
    assign busy       = (state_q != IDLE);
    assign sum_data   = sum_valid ? acc_q : '0;
    assign sum_ovf    = sum_valid & ovf_q;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign len_eff = (len == '0) ? CNT_W'(1) : len;

    acc_sat_adder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_i   (acc_q),
        .add_i   (prod_data),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        start_run = 1'b0;

        case (state_q)
            IDLE: begin
                start_run = beat;
            end
            ACC: begin
                if (beat) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // A beat here implies sum_ready, so the handoff and the new run share the cycle.
                if (sum_ready) begin
                    start_run = beat;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_run) begin
            len_d   = len_eff;
            acc_d   = ACC_W'(prod_data);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (len_eff == CNT_W'(1)) ? HOLD : ACC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: a 48-bit and a 33-bit instance share one product stream,
// and each finished sum is compared with the plain arithmetic total of the run.
module tb_mult_accumulator;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [CW-1:0] len;
    logic          prod_valid;
    logic [DW-1:0] prod_data;
    logic          sum_ready;

    logic          prod_ready_a, sum_valid_a, sum_ovf_a, busy_a;
    logic [47:0]   sum_data_a;
    logic          prod_ready_b, sum_valid_b, sum_ovf_b, busy_b;
    logic [32:0]   sum_data_b;

    int n_checks;
    int n_fail;

    mult_accumulator #(.DATA_W(DW), .ACC_W(48), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready_a),
        .prod_data  (prod_data),
        .sum_valid  (sum_valid_a),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data_a),
        .sum_ovf    (sum_ovf_a),
        .busy       (busy_a)
    );

    mult_accumulator #(.DATA_W(DW), .ACC_W(33), .CNT_W(CW)) dut33 (
        .clk        (clk),
        .rst        (rst),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready_b),
        .prod_data  (prod_data),
        .sum_valid  (sum_valid_b),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data_b),
        .sum_ovf    (sum_ovf_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: true total of the run reduced to w bits.
    function automatic logic [63:0] ref_sum(input logic [63:0] tot, input int w);
        logic [63:0] maxv;
        maxv = (64'd1 << w) - 64'd1;
        if (tot > maxv) begin
`ifdef MULT_ACC_SATURATE_EN
            return maxv;
`else
            return tot & maxv;
`endif
        end
        return tot;
    endfunction

    function automatic logic ref_ovf(input logic [63:0] tot, input int w);
        return (tot >> w) != 64'd0;
    endfunction

    // Called at a negedge; returns at a negedge with the beat accepted and prod_valid low.
    task automatic beat(input logic [DW-1:0] d, input int gaps);
        int n;
        prod_valid = 1'b0;
        repeat (gaps) @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = d;
        #1;
        n = 0;
        while (!prod_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    task automatic expect_sum(input string tag, input logic [63:0] tot);
        chk({tag, "_valid48"}, 64'(sum_valid_a), 64'd1);
        chk({tag, "_data48"},  64'(sum_data_a),  ref_sum(tot, 48));
        chk({tag, "_ovf48"},   64'(sum_ovf_a),   64'(ref_ovf(tot, 48)));
        chk({tag, "_valid33"}, 64'(sum_valid_b), 64'd1);
        chk({tag, "_data33"},  64'(sum_data_b),  ref_sum(tot, 33));
        chk({tag, "_ovf33"},   64'(sum_ovf_b),   64'(ref_ovf(tot, 33)));
        $display("run %s: total=0x%0h sum48=0x%0h sum33=0x%0h ovf33=%0d",
                 tag, tot, sum_data_a, sum_data_b, sum_ovf_b);
    endtask

    initial begin
        logic [63:0] tot;
        logic [DW-1:0] d;
        int l, n, k;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        len        = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        sum_ready  = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_sum_valid", 64'(sum_valid_a), 64'd0);
        chk("rst_sum_data",  64'(sum_data_a),  64'd0);
        chk("rst_sum_ovf",   64'(sum_ovf_a),   64'd0);
        chk("rst_busy",      64'(busy_a),      64'd0);
        chk("rst_prod_ready", 64'(prod_ready_a), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back run of three.
        len = 8'd3;
        beat(32'h10, 0);
        chk("len3_busy_mid", 64'(busy_a), 64'd1);
        chk("len3_no_early_valid", 64'(sum_valid_a), 64'd0);
        beat(32'h3C00, 0);
        beat(32'hC000000, 0);
        expect_sum("len3", 64'hC003C10);

        // Single-beat runs, len=0 treated as 1.
        len = 8'd0;
        beat(32'h2A, 0);
        expect_sum("len0", 64'h2A);
        len = 8'd1;
        beat(32'h2A, 0);
        expect_sum("len1", 64'h2A);

        // Back-pressure in HOLD, then a beat accepted in the release cycle.
        len = 8'd2;
        beat(32'h100, 0);
        sum_ready = 1'b0;
        beat(32'h200, 0);
        expect_sum("stall", 64'h300);
        len        = 8'd1;
        prod_valid = 1'b1;
        prod_data  = 32'h77;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_prod_ready", 64'(prod_ready_a), 64'd0);
            chk("stall_sum_data",   64'(sum_data_a),   64'h300);
            chk("stall_sum_valid",  64'(sum_valid_a),  64'd1);
            @(negedge clk);
        end
        sum_ready = 1'b1;
        #1;
        chk("release_prod_ready", 64'(prod_ready_a), 64'd1);
        @(posedge clk);
        @(negedge clk);
        prod_valid = 1'b0;
        expect_sum("release", 64'h77);

        // Bubbles with len changed mid-run.
        len = 8'd4;
        beat(32'hAA0000, 0);
        len = 8'd9;
        beat(32'hAA0000, 2);
        beat(32'hAA0000, 1);
        beat(32'hAA0000, 0);
        expect_sum("bubbles", 64'h2A80000);

        // Carry out of the 33-bit instance.
        len = 8'd3;
        beat(32'hFFFFFFFF, 0);
        beat(32'hFFFFFFFF, 0);
        beat(32'hFFFFFFFF, 0);
        expect_sum("ovf", 64'h2FFFFFFFD);

        // Reset mid-run discards the partial sum.
        len = 8'd4;
        beat(32'h11, 0);
        beat(32'h22, 0);
        rst = 1'b1;
        #1;
        chk("midrst_busy",      64'(busy_a),      64'd0);
        chk("midrst_sum_valid", 64'(sum_valid_a), 64'd0);
        chk("midrst_busy33",    64'(busy_b),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst_sum_valid", 64'(sum_valid_a), 64'd0);
        len = 8'd1;
        beat(32'h3, 0);
        expect_sum("postrst", 64'h3);

        // Random runs with bubbles, mid-run len changes and sink stalls.
        for (int r = 0; r < 25; r++) begin
            l   = $urandom_range(0, 6);
            n   = (l == 0) ? 1 : l;
            len = CW'(l);
            tot = 64'd0;
            for (int i = 0; i < n; i++) begin
                d   = $urandom;
                tot = tot + 64'(d);
                beat(d, $urandom_range(0, 2));
                len = CW'($urandom_range(0, 255));
            end
            expect_sum($sformatf("rnd%0d", r), tot);
            k = $urandom_range(0, 3);
            if (k > 0) begin
                sum_ready = 1'b0;
                repeat (k) begin
                    @(negedge clk);
                    chk("rnd_stall_valid", 64'(sum_valid_a), 64'd1);
                    chk("rnd_stall_data",  64'(sum_data_b),  ref_sum(tot, 33));
                end
                sum_ready = 1'b1;
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("final_idle", 64'(busy_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
